jtag_host_sequencer: RTL and testbench
======================================

# jtag_host_sequencer

Host-side JTAG master that turns word-level commands into bit-level TCK/TMS/TDI sequences for the on-chip TAP and returns the TDO bits it captures. It sits between a test-control processor or bench and the TAP port of the scan-wrapped ASIC. It sequences the TAP state machine through reset, instruction-register scans and data-register scans (boundary-scan or bypass). TCK is generated at half the system clock rate.

## Interface
- DATA_W, 16: maximum scan length in bits per command.
- LEN_W, 4: width of `cmd_len_m1`, equal to clog2(DATA_W).
- clk  in  1  system clock. TCK = clk/2.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer idle; a command is accepted when cmd_valid & cmd_ready at a clk edge.
- cmd_op  in  2  command type: 0 = TLR_RESET, 1 = SHIFT_IR, 2 = SHIFT_DR, 3 = reserved (treated as TLR_RESET).
- cmd_len_m1  in  LEN_W  scan length minus 1, so 1..DATA_W bits.
- cmd_data  in  DATA_W  TDI bits, shifted LSB first.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid in that cycle.
- rsp_data  out  DATA_W  TDO bits captured, LSB = first bit shifted out; bits at or above the scan length read 0.
- TCK  out  1  test clock.
- TMS  out  1  test mode select.
- TDI  out  1  test data in.
- TDO  in  1  test data out from the TAP.

## Operation
- Each TCK cycle takes two clk phases:
  - ph0: TCK = 0. TMS and TDI are updated on the clk edge entering ph0.
  - ph1: TCK = 1. TDO is registered on the clk edge entering ph1, i.e. the TCK rising edge. The TAP drives TDO on TCK falling edges, so TDO is stable at this point.
- Every command starts and ends with the TAP in Run-Test-Idle (RTI).
- TLR_RESET TMS stream is 1,1,1,1,1,0, giving N = 6 TCK cycles. TDI is 0. rsp_data is 0.
- SHIFT_IR TMS stream:
  - header 1,1,0,0 (SelDR, SelIR, CaptureIR, ShiftIR);
  - then L shift bits, TMS = 0 on all but the last, TMS = 1 on the last (Exit1);
  - then trailer 1,0 (Update, RTI).
  - N = L + 6.
- SHIFT_DR TMS stream: header 1,0,0, then shift as for SHIFT_IR, then trailer 1,0. N = L + 5.
- During shift bit i, TDI = cmd_data[i] and the TDO sampled on that bit goes to rsp_data[i]. TDI is 0 outside shift bits.
- FSM states:
  - RESET_SEQ: entered from reset.
  - IDLE.
  - HEADER: a counter indexes the header pattern.
  - SHIFT: a bit counter runs from 0 to L-1.
  - TRAILER.
  - Transitions: IDLE→RESET_SEQ or HEADER on accept; HEADER→SHIFT; SHIFT→TRAILER after bit L-1; TRAILER→IDLE; RESET_SEQ→IDLE.
- After reset the block runs a TLR_RESET sequence by itself. cmd_ready stays 0 until it completes. This self-reset produces no rsp_valid.
- rsp_valid has no backpressure. The consumer must take the response in the pulse cycle.

## Timing
- Reset values: TCK = 0, TMS = 1, TDI = 0, cmd_ready = 0, rsp_valid = 0, rsp_data = 0, state = RESET_SEQ.
- Command accepted at edge E:
  - cmd_ready falls at E;
  - the first ph0 starts at E;
  - the TCK cycles occupy 2N clks;
  - at edge E + 2N: rsp_valid = 1, cmd_ready = 1, TCK = 0, TMS = 0.
- A new command may be accepted in the rsp_valid cycle. It is back-to-back with no extra idle TCK.
- cmd_data, cmd_op and cmd_len_m1 are latched at acceptance. Input changes afterwards are ignored.
- Reset asserted mid-command: outputs go immediately to their reset values, any pending response is discarded, and the self TLR_RESET sequence restarts.
- L = DATA_W (cmd_len_m1 all ones): all rsp_data bits are valid. The bit counter must not wrap before TRAILER.

## Structure
- Package jtag_host_pkg holds:
  - cmd_op encodings;
  - FSM state enum;
  - IR/DR header TMS patterns and lengths (4 and 3);
  - trailer pattern;
  - TLR sequence length (6).
- One sub-module, jtag_shift_unit, holds the TDI shift register, TDO capture register and bit counter, with load, shift-enable and done signals. The top level holds the phase toggle, FSM and TMS generation.

## Test plan
- Reset release: 6 TCK cycles with TMS = 1,1,1,1,1,0, then cmd_ready = 1 at clk 12, and no rsp_valid.
- SHIFT_IR, L = 3 (cmd_len_m1 = 2), cmd_data = 3'b010, against the scan-wrapped ASIC TAP: TMS = 1,1,0,0,0,0,1,1,0, and TDI on the shift bits is 0,1,0. rsp_data = 0x0001, the IR capture value 3'b001. rsp_valid arrives 18 clks after accept.
- Bypass selected, SHIFT_DR with L = 1: rsp_data = 0x0000 and N = 6.
- Boundary scan register selected with pins a = 3, b = 5, c_in = 1:
  - SHIFT_DR with L = 14 returns the BSR capture word;
  - rsp_data[0] = c_in = 1 and rsp_data[13:10] = sum = 9;
  - rsp_data[15:14] = 0.
- Two commands back-to-back, with cmd_valid held: the second is accepted in the first's rsp_valid cycle. The TCK waveform is continuous with no gap.
- Reset asserted during SHIFT_DR bit 5: TMS = 1 and TCK = 0 immediately, no rsp_valid follows, and the TLR sequence reruns before cmd_ready = 1.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// jtag_host_pkg: command encodings, FSM states and TMS patterns for the JTAG host sequencer
package jtag_host_pkg;
  typedef enum logic [1:0] {OP_TLR = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_RSVD = 2'd3} op_e;
  typedef enum logic [2:0] {RESET_SEQ, IDLE, HEADER, SHIFT, TRAILER} state_e;
  localparam logic [3:0] IR_HDR = 4'b0011;
  localparam logic [3:0] DR_HDR = 4'b0001;
  localparam int IR_HDR_LEN = 4;
  localparam int DR_HDR_LEN = 3;
  localparam logic [1:0] TRL = 2'b01;
  localparam logic [5:0] TLR_SEQ = 6'b011111;
  localparam int TLR_LEN = 6;
  localparam logic [2:0] IR_HDR_LAST = 3'(IR_HDR_LEN - 1);
  localparam logic [2:0] DR_HDR_LAST = 3'(DR_HDR_LEN - 1);
  localparam logic [2:0] TLR_LAST = 3'(TLR_LEN - 1);
  function automatic logic hdr_tms(input logic ir, input logic [1:0] idx);
    return ir ? IR_HDR[idx] : DR_HDR[idx];
  endfunction
endpackage

// File: rtl/jtag_host_sequencer_shift_unit.sv
// jtag_shift_unit: TDI shift register, TDO capture register and scan bit counter
module jtag_shift_unit #(
  parameter int DATA_W = 16,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len_m1,
  input  logic              shift_en,
  input  logic              capture,
  input  logic              tdo,
  output logic              tdi,
  output logic              done,
  output logic [DATA_W-1:0] cap_data
);
  logic [DATA_W-1:0] sr;
  logic [LEN_W-1:0] len_m1, cnt;
  // load clears the capture word so bits beyond the scan length read 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      len_m1 <= '0;
      cnt <= '0;
      cap_data <= '0;
    end else if (load) begin
      sr <= load_data;
      len_m1 <= load_len_m1;
      cnt <= '0;
      cap_data <= '0;
    end else begin
      if (capture) cap_data[cnt] <= tdo;
      if (shift_en) begin
        sr <= sr >> 1;
        cnt <= cnt + 1'b1;
      end
    end
  assign tdi = sr[0];
  assign done = cnt == len_m1;
endmodule

// File: rtl/jtag_host_sequencer.sv
// jtag_host_sequencer: word-level command to TCK/TMS/TDI sequencer with TDO capture
module jtag_host_sequencer import jtag_host_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len_m1,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);
  state_e state, state_n;
  logic [2:0] cnt, cnt_n;
  logic ph, ph_n, is_ir, boot, boot_n, rsp_n, load, shift_en, capture, done, sdi, last;
  jtag_shift_unit #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_shift (
    .clk(clk), .rst(reset), .load(load), .load_data(cmd_data), .load_len_m1(cmd_len_m1),
    .shift_en(shift_en), .capture(capture), .tdo(TDO), .tdi(sdi), .done(done), .cap_data(rsp_data)
  );
  // reset parks the sequencer in ph0 of the first self-reset TCK cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RESET_SEQ;
      cnt <= '0;
      ph <= 1'b0;
      is_ir <= 1'b0;
      boot <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ph <= ph_n;
      boot <= boot_n;
      rsp_valid <= rsp_n;
      if (load) is_ir <= cmd_op == OP_IR;
    end
  // ph0->ph1 samples TDO; ph1->ph0 steps to the next TMS/TDI bit
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ph_n = ~ph;
    boot_n = boot;
    rsp_n = 1'b0;
    load = 1'b0;
    shift_en = 1'b0;
    capture = 1'b0;
    last = state == RESET_SEQ ? cnt == TLR_LAST :
           state == HEADER ? cnt == (is_ir ? IR_HDR_LAST : DR_HDR_LAST) :
           state == SHIFT ? done : cnt[0];
    if (state == IDLE) begin
      ph_n = 1'b0;
      if (cmd_valid) begin
        load = 1'b1;
        cnt_n = '0;
        state_n = (cmd_op == OP_IR || cmd_op == OP_DR) ? HEADER : RESET_SEQ;
      end
    end else if (!ph) begin
      capture = state == SHIFT;
    end else begin
      cnt_n = cnt + 3'd1;
      shift_en = state == SHIFT;
      if (last) begin
        cnt_n = '0;
        state_n = state == HEADER ? SHIFT : state == SHIFT ? TRAILER : IDLE;
        rsp_n = state == TRAILER || (state == RESET_SEQ && !boot);
        boot_n = boot && state != RESET_SEQ;
      end
    end
  end
  assign cmd_ready = state == IDLE;
  assign TCK = ph;
  assign TDI = state == SHIFT && sdi;
  assign TMS = state == RESET_SEQ ? TLR_SEQ[cnt] :
               state == HEADER ? hdr_tms(is_ir, cnt[1:0]) :
               state == SHIFT ? done :
               state == TRAILER ? TRL[cnt[0]] : 1'b0;
endmodule

// File: tb/tb_jtag_host_sequencer.sv
// tb_jtag_host_sequencer: directed checks of the sequencer against a behavioural scan-wrapped TAP
module tb_jtag_host_sequencer;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_len_m1 = '0;
  logic [15:0] cmd_data = '0, rsp_data;
  logic cmd_ready, rsp_valid, TCK, TMS, TDI;
  logic TDO = 1'b0;
  int checks = 0, errors = 0;

  jtag_host_sequencer dut (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len_m1(cmd_len_m1), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 clk = ~clk;

  typedef enum logic [3:0] {T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
                            T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tap_e;
  localparam logic [2:0] IR_BYP = 3'b111, IR_BSR = 3'b010;
  localparam logic [3:0] PA = 4'd3, PB = 4'd5;
  localparam logic PC = 1'b1;
  localparam logic [4:0] PS = 5'(PA + PB + PC);
  localparam logic [13:0] BSR_CAP = {PS[3:0], PS[4], PB, PA, PC};
  tap_e tap = T_TLR;
  logic [2:0] ir = IR_BYP, ir_sr = '0;
  logic byp = 1'b0;
  logic [13:0] bsr = '0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      T_TLR:  return m ? T_TLR : T_RTI;
      T_RTI:  return m ? T_SDR : T_RTI;
      T_SDR:  return m ? T_SIR : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR : T_SHDR;
      T_UDR:  return m ? T_SDR : T_RTI;
      T_SIR:  return m ? T_TLR : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR : T_SHIR;
      default: return m ? T_SDR : T_RTI;
    endcase
  endfunction

  always @(posedge TCK) begin
    case (tap)
      T_TLR:  ir <= IR_BYP;
      T_CIR:  ir_sr <= 3'b001;
      T_SHIR: ir_sr <= {TDI, ir_sr[2:1]};
      T_UIR:  ir <= ir_sr;
      T_CDR:  begin byp <= 1'b0; bsr <= BSR_CAP; end
      T_SHDR: begin byp <= TDI; bsr <= {TDI, bsr[13:1]}; end
      default: ;
    endcase
    tap <= tap_next(tap, TMS);
  end

  always @(negedge TCK)
    TDO <= tap == T_SHIR ? ir_sr[0] : tap == T_SHDR ? (ir == IR_BSR ? bsr[0] : byp) : 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic boot_check(input string tag);
    logic [31:0] tl;
    int nb, seen;
    tl = '0;
    nb = 0;
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (TCK && nb < 32) begin tl[nb] = TMS; nb++; end
      if (rsp_valid) seen++;
      if (k == 11) chk({tag, "_busy"}, 32'(cmd_ready), 0);
    end
    chk({tag, "_tms"}, tl, 32'h1F);
    chk({tag, "_tcks"}, nb, 6);
    chk({tag, "_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_norsp"}, seen, 0);
    chk({tag, "_tap"}, 32'(tap == T_RTI), 1);
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] lm1,
                         input logic [15:0] d, input logic [15:0] exp_rsp, input int exp_clks,
                         output logic [31:0] tl, output logic [31:0] dl);
    int k, nb;
    tl = '0;
    dl = '0;
    nb = 0;
    chk({tag, "_ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_len_m1 = lm1;
    cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = ~op;
    cmd_len_m1 = ~lm1;
    cmd_data = ~d;
    k = 0;
    while (!rsp_valid && k < 200) begin
      if (TCK && nb < 32) begin tl[nb] = TMS; dl[nb] = TDI; nb++; end
      @(negedge clk);
      k++;
    end
    chk({tag, "_clks"}, k, exp_clks);
    chk({tag, "_rsp"}, 32'(rsp_data), 32'(exp_rsp));
    chk({tag, "_tap"}, 32'(tap == T_RTI), 1);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [31:0] tl, dl;
    int k, seen;
    @(negedge clk);
    chk("rst_tck", 32'(TCK), 0);
    chk("rst_tms", 32'(TMS), 1);
    chk("rst_tdi", 32'(TDI), 0);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_rspd", 32'(rsp_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    boot_check("boot");
    run_cmd("tlr", 2'd0, 4'd0, 16'hFFFF, 16'h0000, 12, tl, dl);
    run_cmd("ir", 2'd1, 4'd2, 16'h0002, 16'h0001, 18, tl, dl);
    chk("ir_tms", tl, 32'h0C3);
    chk("ir_tdi", dl, 32'h020);
    chk("ir_val", 32'(ir), 32'(IR_BSR));
    run_cmd("bsr14", 2'd2, 4'd13, 16'h0000, 16'h24A7, 38, tl, dl);
    chk("bsr14_tms", tl, 32'h30001);
    run_cmd("bsr16", 2'd2, 4'd15, 16'h0003, 16'hE4A7, 42, tl, dl);
    chk("bsr16_tdi", dl, 32'h018);
    chk("b2b_ready0", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    cmd_len_m1 = 4'd2;
    cmd_data = 16'h0007;
    @(negedge clk);
    cmd_op = 2'd2;
    cmd_len_m1 = 4'd0;
    cmd_data = 16'h0000;
    k = 0;
    while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
    chk("b2b_clks1", k, 18);
    chk("b2b_rsp1", 32'(rsp_data), 1);
    chk("b2b_ready1", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_tck", 32'(TCK), 0);
    chk("b2b_busy", 32'(cmd_ready), 0);
    k = 1;
    while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
    chk("b2b_clks2", k, 13);
    chk("b2b_rsp2", 32'(rsp_data), 0);
    chk("b2b_ir", 32'(ir), 32'(IR_BYP));
    @(negedge clk);
    run_cmd("byp2", 2'd2, 4'd1, 16'h0001, 16'h0002, 14, tl, dl);
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    cmd_len_m1 = 4'd13;
    cmd_data = 16'h0020;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_tck1", 32'(TCK), 1);
    chk("mid_tdi1", 32'(TDI), 1);
    chk("mid_tms0", 32'(TMS), 0);
    rst = 1'b1;
    #1;
    chk("mid_tck", 32'(TCK), 0);
    chk("mid_tms", 32'(TMS), 1);
    chk("mid_tdi", 32'(TDI), 0);
    chk("mid_ready", 32'(cmd_ready), 0);
    chk("mid_rspv", 32'(rsp_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    boot_check("reboot");
    seen = 0;
    repeat (40) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("mid_norsp", seen, 0);
    run_cmd("rsvd", 2'd3, 4'd5, 16'hFFFF, 16'h0000, 12, tl, dl);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
